// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage access unit.
//   op_t      : request opcodes presented by the MEM pipeline stage
//   state_t   : access sequencer states
//   sp_ctrl_t : stack pointer update commands
package mem_pkg;

  localparam int unsigned N_DEFAULT = 10;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDD  = 3'd1,
    OP_STD  = 3'd2,
    OP_PUSH = 3'd3,
    OP_POP  = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RET_LO  = 3'd2,
    ST_RET_HI  = 3'd3,
    ST_CALL_LO = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    SP_HOLD = 3'd0,
    SP_INC1 = 3'd1,
    SP_INC2 = 3'd2,
    SP_DEC1 = 3'd3,
    SP_DEC2 = 3'd4
  } sp_ctrl_t;

endpackage

// File: rtl/mem_access_unit_stack_pointer.sv
// Stack pointer register with modulo-2^N neighbour addresses.
//   clk, rst : clock, synchronous active-high reset (sp <= SP_INIT)
//   ctrl     : hold / +1 / +2 / -1 / -2 update applied at posedge
//   sp       : current stack pointer
//   sp_p1/p2 : sp+1, sp+2 (mod 2^N)
//   sp_m1    : sp-1 (mod 2^N)
module stack_pointer
  import mem_pkg::*;
#(
  parameter int unsigned N       = N_DEFAULT,
  parameter int unsigned SP_INIT = (1 << N) - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  sp_ctrl_t     ctrl,
  output logic [N-1:0] sp,
  output logic [N-1:0] sp_p1,
  output logic [N-1:0] sp_p2,
  output logic [N-1:0] sp_m1
);

  logic [N-1:0] sp_m2;

  always_comb begin
    sp_p1 = sp + N'(1);
    sp_p2 = sp + N'(2);
    sp_m1 = sp - N'(1);
    sp_m2 = sp - N'(2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= N'(SP_INIT);
    end else begin
      case (ctrl)
        SP_INC1: sp <= sp_p1;
        SP_INC2: sp <= sp_p2;
        SP_DEC1: sp <= sp_m1;
        SP_DEC2: sp <= sp_m2;
        default: sp <= sp;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage initiator: turns LDD/STD/PUSH/POP/CALL/RET requests into
// data-memory read/write strobes, owns the stack pointer and splits 32-bit
// PC push/pop into two 16-bit accesses.
//   req_*          : request from the MEM stage (sampled only in IDLE)
//   stall          : holds upstream stages (combinational)
//   resp_valid     : one-cycle pulse qualifying resp_data / resp_pc
//   sp             : stack pointer, zero-extended to 16 bits
//   mem_*          : data memory ports; read data arrives at the negedge
//                    after the posedge that sampled the read address
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned N       = N_DEFAULT,
  parameter int unsigned SP_INIT = (1 << N) - 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        stall,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic [31:0] resp_pc,
  output logic [15:0] sp,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [15:0] mem_read_addr,
  output logic [15:0] mem_write_addr,
  output logic [15:0] mem_write_data,
  input  logic [15:0] mem_read_data
);

  state_t       state, state_next;
  sp_ctrl_t     sp_ctrl;
  op_t          op;
  logic [N-1:0] sp_cur, sp_p1, sp_p2, sp_m1;

  stack_pointer #(
    .N       (N),
    .SP_INIT (SP_INIT)
  ) u_sp (
    .clk   (clk),
    .rst   (rst),
    .ctrl  (sp_ctrl),
    .sp    (sp_cur),
    .sp_p1 (sp_p1),
    .sp_p2 (sp_p2),
    .sp_m1 (sp_m1)
  );

  assign sp = 16'(sp_cur);
  assign op = op_t'(req_op);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_pc    <= '0;
    end else begin
      resp_valid <= (state == ST_RD_WAIT) || (state == ST_RET_HI);
      if (state == ST_RD_WAIT) resp_data      <= mem_read_data;
      if (state == ST_RET_LO)  resp_pc[15:0]  <= mem_read_data;
      if (state == ST_RET_HI)  resp_pc[31:16] <= mem_read_data;
    end
  end

  // CALL_LO leaves stall low: the request was held for exactly one extra
  // cycle, so the next instruction arrives in the cycle after CALL_LO.
  always_comb begin
    state_next       = state;
    sp_ctrl          = SP_HOLD;
    stall            = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_read_addr    = '0;
    mem_write_addr   = '0;
    mem_write_data   = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          case (op)
            OP_STD: begin
              mem_write_enable = 1'b1;
              mem_write_addr   = req_addr;
              mem_write_data   = req_wdata;
            end
            OP_PUSH: begin
              mem_write_enable = 1'b1;
              mem_write_addr   = sp;
              mem_write_data   = req_wdata;
              sp_ctrl          = SP_DEC1;
            end
            OP_LDD: begin
              mem_read_enable = 1'b1;
              mem_read_addr   = req_addr;
              stall           = 1'b1;
              state_next      = ST_RD_WAIT;
            end
            OP_POP: begin
              mem_read_enable = 1'b1;
              mem_read_addr   = 16'(sp_p1);
              sp_ctrl         = SP_INC1;
              stall           = 1'b1;
              state_next      = ST_RD_WAIT;
            end
            OP_CALL: begin
              mem_write_enable = 1'b1;
              mem_write_addr   = sp;
              mem_write_data   = req_pc[31:16];
              stall            = 1'b1;
              state_next       = ST_CALL_LO;
            end
            OP_RET: begin
              mem_read_enable = 1'b1;
              mem_read_addr   = 16'(sp_p1);
              stall           = 1'b1;
              state_next      = ST_RET_LO;
            end
            default: ;
          endcase
        end
      end
      ST_RD_WAIT: begin
        stall      = 1'b1;
        state_next = ST_IDLE;
      end
      ST_RET_LO: begin
        stall           = 1'b1;
        mem_read_enable = 1'b1;
        mem_read_addr   = 16'(sp_p2);
        state_next      = ST_RET_HI;
      end
      ST_RET_HI: begin
        stall      = 1'b1;
        sp_ctrl    = SP_INC2;
        state_next = ST_IDLE;
      end
      ST_CALL_LO: begin
        mem_write_enable = 1'b1;
        mem_write_addr   = 16'(sp_m1);
        mem_write_data   = req_pc[15:0];
        sp_ctrl          = SP_DEC2;
        state_next       = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data memory
// (address sampled at posedge, data presented at the following negedge).
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [15:0] req_addr, req_wdata;
  logic [31:0] req_pc;
  logic        stall, resp_valid;
  logic [15:0] resp_data, sp;
  logic [31:0] resp_pc;
  logic        mem_read_enable, mem_write_enable;
  logic [15:0] mem_read_addr, mem_write_addr, mem_write_data;
  logic [15:0] mem_read_data;

  logic [15:0] mem [0:1023];
  logic [15:0] rd_addr_q;
  logic        mem_clr;
  logic [49:0] mem_bus;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_cnt;

  mem_access_unit #(.N(10), .SP_INIT(1023)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_op           (req_op),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_pc           (req_pc),
    .stall            (stall),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .resp_pc          (resp_pc),
    .sp               (sp),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_read_addr    (mem_read_addr),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_bus = {mem_read_enable, mem_write_enable, mem_read_addr, mem_write_addr, mem_write_data};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      rd_addr_q <= '0;
    end else begin
      if (mem_write_enable) mem[mem_write_addr[9:0]] <= mem_write_data;
      if (mem_read_enable)  rd_addr_q <= mem_read_addr;
    end
  end

  always @(negedge clk) mem_read_data <= mem[rd_addr_q[9:0]];

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] d, input logic [31:0] pc);
    req_valid = v; req_op = op; req_addr = a; req_wdata = d; req_pc = pc;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1'b0, OP_NOP, 16'h0, 16'h0, 32'h0); #1;
    n_cmp++; if (sp !== 16'h03FF) begin n_bad++; $display("FAIL reset_sp: got %h want 03ff", sp); end
    n_cmp++; if ({resp_valid, resp_data, resp_pc} !== 49'h0) begin n_bad++; $display("FAIL reset_resp: got %b/%h/%h want 0", resp_valid, resp_data, resp_pc); end
    n_cmp++; if ({stall, mem_bus} !== 51'h0) begin n_bad++; $display("FAIL reset_mem: got stall=%b bus=%h want 0", stall, mem_bus); end
    next_cycle();
  endtask

  task automatic test_push_pop();
    drive(1'b1, OP_PUSH, 16'h0, 16'h1234, 32'h0); #1;
    n_cmp++; if ({stall, mem_bus} !== {1'b0, 1'b0, 1'b1, 16'h0000, 16'h03FF, 16'h1234}) begin n_bad++; $display("FAIL push_strobe: got stall=%b bus=%h", stall, mem_bus); end
    next_cycle();
    drive(1'b1, OP_POP, 16'h0, 16'h0, 32'h0); #1;
    n_cmp++; if (sp !== 16'h03FE) begin n_bad++; $display("FAIL push_sp: got %h want 03fe", sp); end
    n_cmp++; if (mem[10'h3FF] !== 16'h1234) begin n_bad++; $display("FAIL push_mem: got %h want 1234", mem[10'h3FF]); end
    n_cmp++; if ({stall, mem_bus} !== {1'b1, 1'b1, 1'b0, 16'h03FF, 16'h0000, 16'h0000}) begin n_bad++; $display("FAIL pop_strobe: got stall=%b bus=%h", stall, mem_bus); end
    next_cycle(); #1;
    n_cmp++; if ({stall, resp_valid, mem_bus, sp} !== {1'b1, 1'b0, 50'h0, 16'h03FF}) begin n_bad++; $display("FAIL pop_wait: got stall=%b rv=%b bus=%h sp=%h", stall, resp_valid, mem_bus, sp); end
    next_cycle();
    drive(1'b0, OP_NOP, 16'h0, 16'h0, 32'h0); #1;
    n_cmp++; if ({stall, resp_valid, resp_data} !== {1'b0, 1'b1, 16'h1234}) begin n_bad++; $display("FAIL pop_resp: got stall=%b rv=%b data=%h want 0/1/1234", stall, resp_valid, resp_data); end
    next_cycle(); #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL pop_pulse: got %b want 0", resp_valid); end
  endtask

  task automatic test_std_ldd();
    drive(1'b1, OP_STD, 16'h0010, 16'hBEEF, 32'h0); #1;
    n_cmp++; if ({stall, mem_bus} !== {1'b0, 1'b0, 1'b1, 16'h0000, 16'h0010, 16'hBEEF}) begin n_bad++; $display("FAIL std_strobe: got stall=%b bus=%h", stall, mem_bus); end
    next_cycle();
    stall_cnt = 0;
    drive(1'b1, OP_LDD, 16'h0010, 16'h0, 32'h0); #1;
    n_cmp++; if ({mem_read_enable, mem_write_enable, mem_read_addr} !== {1'b1, 1'b0, 16'h0010}) begin n_bad++; $display("FAIL ldd_strobe: got bus=%h", mem_bus); end
    if (stall === 1'b1) stall_cnt++;
    next_cycle(); #1;
    if (stall === 1'b1) stall_cnt++;
    next_cycle();
    drive(1'b0, OP_NOP, 16'h0, 16'h0, 32'h0); #1;
    if (stall === 1'b1) stall_cnt++;
    n_cmp++; if ({resp_valid, resp_data} !== {1'b1, 16'hBEEF}) begin n_bad++; $display("FAIL ldd_resp: got rv=%b data=%h want 1/beef", resp_valid, resp_data); end
    n_cmp++; if (stall_cnt !== 2) begin n_bad++; $display("FAIL ldd_stall_len: got %0d cycles want 2", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, OP_STD, 16'h0020, 16'h5555, 32'h0); next_cycle();
    drive(1'b1, OP_LDD, 16'h0010, 16'h0, 32'h0);    next_cycle();
    next_cycle();
    drive(1'b1, OP_LDD, 16'h0020, 16'h0, 32'h0); #1;
    n_cmp++; if ({resp_valid, resp_data, stall, mem_read_enable, mem_read_addr} !== {1'b1, 16'hBEEF, 1'b1, 1'b1, 16'h0020}) begin n_bad++; $display("FAIL b2b_accept: got rv=%b data=%h stall=%b bus=%h", resp_valid, resp_data, stall, mem_bus); end
    next_cycle(); #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got rv=%b want 0", resp_valid); end
    next_cycle();
    drive(1'b0, OP_NOP, 16'h0, 16'h0, 32'h0); #1;
    n_cmp++; if ({resp_valid, resp_data} !== {1'b1, 16'h5555}) begin n_bad++; $display("FAIL b2b_resp: got rv=%b data=%h want 1/5555", resp_valid, resp_data); end
    next_cycle();
  endtask

  task automatic test_call_ret();
    drive(1'b1, OP_CALL, 16'h0, 16'h0, 32'h0001_0040); #1;
    n_cmp++; if ({stall, mem_bus} !== {1'b1, 1'b0, 1'b1, 16'h0000, 16'h03FF, 16'h0001}) begin n_bad++; $display("FAIL call_hi: got stall=%b bus=%h", stall, mem_bus); end
    next_cycle(); #1;
    n_cmp++; if ({stall, mem_bus, sp} !== {1'b0, 1'b0, 1'b1, 16'h0000, 16'h03FE, 16'h0040, 16'h03FF}) begin n_bad++; $display("FAIL call_lo: got stall=%b bus=%h sp=%h", stall, mem_bus, sp); end
    next_cycle();
    drive(1'b1, OP_RET, 16'h0, 16'h0, 32'h0); #1;
    n_cmp++; if ({sp, mem[10'h3FF], mem[10'h3FE]} !== {16'h03FD, 16'h0001, 16'h0040}) begin n_bad++; $display("FAIL call_state: got sp=%h m3ff=%h m3fe=%h", sp, mem[10'h3FF], mem[10'h3FE]); end
    n_cmp++; if ({stall, mem_bus} !== {1'b1, 1'b1, 1'b0, 16'h03FE, 16'h0000, 16'h0000}) begin n_bad++; $display("FAIL ret_rd_lo: got stall=%b bus=%h", stall, mem_bus); end
    next_cycle(); #1;
    n_cmp++; if ({stall, mem_bus} !== {1'b1, 1'b1, 1'b0, 16'h03FF, 16'h0000, 16'h0000}) begin n_bad++; $display("FAIL ret_rd_hi: got stall=%b bus=%h", stall, mem_bus); end
    next_cycle(); #1;
    n_cmp++; if ({stall, resp_valid, mem_bus} !== {1'b1, 1'b0, 50'h0}) begin n_bad++; $display("FAIL ret_wait: got stall=%b rv=%b bus=%h", stall, resp_valid, mem_bus); end
    next_cycle();
    drive(1'b0, OP_NOP, 16'h0, 16'h0, 32'h0); #1;
    n_cmp++; if ({stall, resp_valid, resp_pc, sp} !== {1'b0, 1'b1, 32'h0001_0040, 16'h03FF}) begin n_bad++; $display("FAIL ret_resp: got stall=%b rv=%b pc=%h sp=%h", stall, resp_valid, resp_pc, sp); end
    next_cycle();
  endtask

  task automatic test_ignore_inputs();
    drive(1'b1, OP_LDD, 16'h0010, 16'h0, 32'h0); next_cycle();
    drive(1'b1, OP_STD, 16'h0030, 16'hDEAD, 32'h0); #1;
    n_cmp++; if ({stall, mem_bus} !== {1'b1, 50'h0}) begin n_bad++; $display("FAIL ignore_strobe: got stall=%b bus=%h", stall, mem_bus); end
    next_cycle();
    drive(1'b0, OP_NOP, 16'h0, 16'h0, 32'h0); #1;
    n_cmp++; if ({resp_valid, resp_data, mem[10'h030]} !== {1'b1, 16'hBEEF, 16'h0000}) begin n_bad++; $display("FAIL ignore_resp: got rv=%b data=%h m030=%h", resp_valid, resp_data, mem[10'h030]); end
    next_cycle();
  endtask

  task automatic test_wrap();
    drive(1'b1, OP_STD, 16'h0000, 16'hA5A5, 32'h0); next_cycle();
    drive(1'b1, OP_POP, 16'h0, 16'h0, 32'h0); #1;
    n_cmp++; if ({mem_read_enable, mem_read_addr} !== {1'b1, 16'h0000}) begin n_bad++; $display("FAIL wrap_pop_addr: got bus=%h want rd 0000", mem_bus); end
    next_cycle(); #1;
    n_cmp++; if (sp !== 16'h0000) begin n_bad++; $display("FAIL wrap_pop_sp: got %h want 0000", sp); end
    next_cycle();
    drive(1'b1, OP_PUSH, 16'h0, 16'h7777, 32'h0); #1;
    n_cmp++; if ({resp_valid, resp_data, mem_bus} !== {1'b1, 16'hA5A5, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h7777}) begin n_bad++; $display("FAIL wrap_push: got rv=%b data=%h bus=%h", resp_valid, resp_data, mem_bus); end
    next_cycle();
    drive(1'b0, OP_NOP, 16'h0, 16'h0, 32'h0); #1;
    n_cmp++; if ({sp, mem[10'h000]} !== {16'h03FF, 16'h7777}) begin n_bad++; $display("FAIL wrap_push_sp: got sp=%h m000=%h", sp, mem[10'h000]); end
    next_cycle();
  endtask

  task automatic test_reset_mid_ret();
    drive(1'b1, OP_CALL, 16'h0, 16'h0, 32'hCAFE_0123); next_cycle(); next_cycle();
    drive(1'b1, OP_RET, 16'h0, 16'h0, 32'h0); next_cycle();
    rst = 1'b1; next_cycle();
    rst = 1'b0;
    drive(1'b0, OP_NOP, 16'h0, 16'h0, 32'h0); #1;
    n_cmp++; if ({stall, resp_valid, mem_bus, sp} !== {1'b0, 1'b0, 50'h0, 16'h03FF}) begin n_bad++; $display("FAIL rst_mid_ret: got stall=%b rv=%b bus=%h sp=%h", stall, resp_valid, mem_bus, sp); end
    next_cycle();
    drive(1'b1, OP_PUSH, 16'h0, 16'h1111, 32'h0); #1;
    n_cmp++; if ({resp_valid, resp_pc, stall, mem_bus} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h03FF, 16'h1111}) begin n_bad++; $display("FAIL rst_after: got rv=%b pc=%h stall=%b bus=%h", resp_valid, resp_pc, stall, mem_bus); end
    next_cycle();
    drive(1'b0, OP_NOP, 16'h0, 16'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    mem_clr = 1'b1;
    drive(1'b0, OP_NOP, 16'h0, 16'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_clr = 1'b0;
    test_reset();
    test_push_pop();
    test_std_ldd();
    test_back_to_back();
    test_call_ret();
    test_ignore_inputs();
    test_wrap();
    test_reset_mid_ret();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
